// File: rtl/digest_serializer.sv
// digest_serializer: latches a digest and streams it to a UART transmitter one byte at a time.
// Define DIGEST_SERIALIZER_HEX_ASCII_EN to send the digest as lowercase hex text followed by CR LF.
module digest_serializer #(
  parameter int DATA_WIDTH    = 32,
  parameter int WORD_COUNT    = 8,
  parameter int TIMEOUT_LIMIT = 4340
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*WORD_COUNT-1:0] digest_in,
  input  logic                             digest_dv_in,
  input  logic                             tx_done_in,
  output logic [7:0]                       tx_byte_out,
  output logic                             tx_dv_out,
  output logic                             DS_busy_out,
  output logic                             DS_done_out,
  output logic                             DS_err_out,
  output logic [6:0]                       DS_counter_out
);

  localparam int DIGEST_BITS = DATA_WIDTH * WORD_COUNT;
  localparam int NUM_BYTES   = DIGEST_BITS / 8;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int NUM_CHARS   = 2 * NUM_BYTES + 2;
`else
  localparam int NUM_CHARS   = NUM_BYTES;
`endif
  localparam logic [6:0] LAST_INDEX = 7'(NUM_CHARS - 1);
  localparam int TW = $clog2(TIMEOUT_LIMIT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

  state_t                 state;
  logic [DIGEST_BITS-1:0] shift_reg;
  logic [TW-1:0]          timeout_cnt;
  logic [7:0]             top_byte;
  logic [7:0]             next_char;
  logic                   shift_now;

  assign top_byte = shift_reg[DIGEST_BITS-1 -: 8];

`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h57 + {4'h0, n};
  endfunction

  // Even indices carry the high nibble; the register only advances after the low nibble.
  always_comb begin
    next_char = 8'h00;
    if (DS_counter_out == 7'(2 * NUM_BYTES))
      next_char = 8'h0D;
    else if (DS_counter_out == 7'(2 * NUM_BYTES + 1))
      next_char = 8'h0A;
    else if (!DS_counter_out[0])
      next_char = hex_char(top_byte[7:4]);
    else
      next_char = hex_char(top_byte[3:0]);
  end

  assign shift_now = DS_counter_out[0] && (DS_counter_out < 7'(2 * NUM_BYTES));
`else
  assign next_char = top_byte;
  assign shift_now = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      shift_reg      <= '0;
      timeout_cnt    <= '0;
      tx_byte_out    <= 8'h00;
      tx_dv_out      <= 1'b0;
      DS_busy_out    <= 1'b0;
      DS_done_out    <= 1'b0;
      DS_err_out     <= 1'b0;
      DS_counter_out <= 7'd0;
    end else begin
      tx_dv_out   <= 1'b0;
      DS_done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (digest_dv_in) begin
            shift_reg      <= digest_in;
            DS_counter_out <= 7'd0;
            DS_err_out     <= 1'b0;
            DS_busy_out    <= 1'b1;
            state          <= LOAD;
          end
        end
        LOAD: begin
          tx_byte_out <= next_char;
          state       <= SEND;
        end
        SEND: begin
          tx_dv_out   <= 1'b1;
          timeout_cnt <= '0;
          state       <= WAIT;
        end
        // A done arriving on the final allowed cycle still wins over the timeout.
        WAIT: begin
          if (tx_done_in) begin
            if (DS_counter_out == LAST_INDEX) begin
              state <= DONE;
            end else begin
              DS_counter_out <= DS_counter_out + 7'd1;
              if (shift_now)
                shift_reg <= {shift_reg[DIGEST_BITS-9:0], 8'h00};
              state <= LOAD;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            DS_err_out  <= 1'b1;
            DS_busy_out <= 1'b0;
            state       <= IDLE;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        DONE: begin
          DS_done_out <= 1'b1;
          DS_busy_out <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: drives digests through digest_serializer with a UART responder
// and compares every transmitted byte against a byte/hex reference model.
module tb_digest_serializer;

  localparam int TL = 40;
  localparam logic [255:0] ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
  localparam int N_CHARS = 66;
`else
  localparam int N_CHARS = 32;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] digest_in;
  logic         digest_dv_in;
  logic         tx_done_in;
  logic [7:0]   tx_byte_out;
  logic         tx_dv_out;
  logic         DS_busy_out;
  logic         DS_done_out;
  logic         DS_err_out;
  logic [6:0]   DS_counter_out;

  int vectors = 0;
  int miscompares = 0;
  int dv_pulses = 0;
  int done_pulses = 0;
  logic [7:0] rx [0:127];
  int rx_count;

  typedef struct {
    int         idx;
    logic [7:0] exp;
  } vec_t;
  vec_t table_v [8];

  digest_serializer #(
    .DATA_WIDTH(32),
    .WORD_COUNT(8),
    .TIMEOUT_LIMIT(TL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digest_in(digest_in),
    .digest_dv_in(digest_dv_in),
    .tx_done_in(tx_done_in),
    .tx_byte_out(tx_byte_out),
    .tx_dv_out(tx_dv_out),
    .DS_busy_out(DS_busy_out),
    .DS_done_out(DS_done_out),
    .DS_err_out(DS_err_out),
    .DS_counter_out(DS_counter_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_dv_out) dv_pulses++;
    if (DS_done_out) done_pulses++;
  end

  // Expected character k of the stream, derived directly from the digest value.
  function automatic logic [7:0] model_char(input logic [255:0] d, input int k);
    logic [7:0] b;
    logic [3:0] n;
`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    if (k == 64) return 8'h0D;
    if (k == 65) return 8'h0A;
    b = d[255 - 8 * (k / 2) -: 8];
    n = (k % 2 == 0) ? b[7:4] : b[3:0];
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h61 + {4'h0, n} - 8'd10;
`else
    n = 4'h0;
    b = d[255 - 8 * k -: 8];
    return b + {4'h0, n};
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic pulse_digest(input logic [255:0] d);
    digest_in = d;
    digest_dv_in = 1'b1;
    @(negedge clk);
    digest_dv_in = 1'b0;
    digest_in = '0;
  endtask

  task automatic wait_dv(output bit ok);
    int waited = 0;
    while (!tx_dv_out && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    ok = tx_dv_out;
    if (!ok) check_output("tx_dv_wait", 32'd0, 32'd1);
  endtask

  // Full transfer with optional ignored digest, doubled done, boundary-late done, or reset abort.
  task automatic apply_stimulus(input logic [255:0] dig, input int delay, input int inject_idx,
                                input int dbl_idx, input int slow_idx, input int abort_idx);
    int dv0, done0, dly, waited;
    bit ok;
    dv0 = dv_pulses;
    done0 = done_pulses;
    rx_count = 0;
    pulse_digest(dig);
    check_output("err_cleared", 32'(DS_err_out), 32'd0);
    check_output("busy_set", 32'(DS_busy_out), 32'd1);
    for (int k = 0; k < N_CHARS; k++) begin
      wait_dv(ok);
      if (!ok) return;
      rx[k] = tx_byte_out;
      rx_count++;
      check_output($sformatf("counter[%0d]", k), 32'(DS_counter_out), 32'(k));
      check_output($sformatf("byte[%0d]", k), 32'(tx_byte_out), 32'(model_char(dig, k)));
      if (k == abort_idx) begin
        #2 rst = 1'b1;
        #1;
        check_output("rst_byte", 32'(tx_byte_out), 32'd0);
        check_output("rst_dv", 32'(tx_dv_out), 32'd0);
        check_output("rst_busy", 32'(DS_busy_out), 32'd0);
        check_output("rst_done", 32'(DS_done_out), 32'd0);
        check_output("rst_err", 32'(DS_err_out), 32'd0);
        check_output("rst_counter", 32'(DS_counter_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dv0 = dv_pulses;
        repeat (20) @(negedge clk);
        check_output("abort_no_dv", 32'(dv_pulses - dv0), 32'd0);
        check_output("abort_no_done", 32'(done_pulses - done0), 32'd0);
        return;
      end
      dly = (k == slow_idx) ? TL - 1 : delay;
      for (int d = 0; d < dly; d++) begin
        if (k == inject_idx && d == 0) begin
          digest_in = '1;
          digest_dv_in = 1'b1;
        end
        @(negedge clk);
        digest_dv_in = 1'b0;
        digest_in = '0;
      end
      tx_done_in = 1'b1;
      @(negedge clk);
      if (k == dbl_idx) @(negedge clk);
      tx_done_in = 1'b0;
    end
    waited = 0;
    while (!DS_done_out && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_output("done_pulse", 32'(DS_done_out), 32'd1);
    @(negedge clk);
    check_output("dv_total", 32'(dv_pulses - dv0), 32'(N_CHARS));
    check_output("done_total", 32'(done_pulses - done0), 32'd1);
    check_output("busy_clear", 32'(DS_busy_out), 32'd0);
    check_output("err_clear", 32'(DS_err_out), 32'd0);
  endtask

  task automatic run_timeout();
    int dv0, done0;
    bit ok;
    done0 = done_pulses;
    pulse_digest(ABC);
    for (int k = 0; k < 4; k++) begin
      wait_dv(ok);
      if (!ok) return;
      check_output($sformatf("to_byte[%0d]", k), 32'(tx_byte_out), 32'(model_char(ABC, k)));
      if (k < 3) begin
        repeat (2) @(negedge clk);
        tx_done_in = 1'b1;
        @(negedge clk);
        tx_done_in = 1'b0;
      end
    end
    repeat (TL - 1) @(negedge clk);
    check_output("err_before_limit", 32'(DS_err_out), 32'd0);
    check_output("busy_before_limit", 32'(DS_busy_out), 32'd1);
    @(negedge clk);
    check_output("err_at_limit", 32'(DS_err_out), 32'd1);
    check_output("busy_after_timeout", 32'(DS_busy_out), 32'd0);
    check_output("counter_at_timeout", 32'(DS_counter_out), 32'd3);
    dv0 = dv_pulses;
    repeat (20) @(negedge clk);
    check_output("timeout_no_dv", 32'(dv_pulses - dv0), 32'd0);
    check_output("timeout_no_done", 32'(done_pulses - done0), 32'd0);
    check_output("err_sticky", 32'(DS_err_out), 32'd1);
  endtask

  initial begin
    int dv0;
    logic [6:0] cnt0;
    logic [255:0] rnd;
    rst = 1'b1;
    digest_in = '0;
    digest_dv_in = 1'b0;
    tx_done_in = 1'b0;

`ifdef DIGEST_SERIALIZER_HEX_ASCII_EN
    table_v = '{'{0, 8'h62}, '{1, 8'h61}, '{2, 8'h37}, '{3, 8'h38},
                '{62, 8'h61}, '{63, 8'h64}, '{64, 8'h0D}, '{65, 8'h0A}};
`else
    table_v = '{'{0, 8'hBA}, '{1, 8'h78}, '{2, 8'h16}, '{3, 8'hBF},
                '{28, 8'hF2}, '{29, 8'h00}, '{30, 8'h15}, '{31, 8'hAD}};
`endif

    repeat (3) @(negedge clk);
    check_output("reset_byte", 32'(tx_byte_out), 32'd0);
    check_output("reset_dv", 32'(tx_dv_out), 32'd0);
    check_output("reset_busy", 32'(DS_busy_out), 32'd0);
    check_output("reset_done", 32'(DS_done_out), 32'd0);
    check_output("reset_err", 32'(DS_err_out), 32'd0);
    check_output("reset_counter", 32'(DS_counter_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] abc digest, done 10 cycles after each byte");
    apply_stimulus(ABC, 10, -1, -1, -1, -1);
    check_output("rx_count", 32'(rx_count), 32'(N_CHARS));
    for (int i = 0; i < 8; i++)
      check_output($sformatf("table[%0d]", table_v[i].idx), 32'(rx[table_v[i].idx]), 32'(table_v[i].exp));

    $display("[TB] tx_done in IDLE is ignored");
    cnt0 = DS_counter_out;
    dv0 = dv_pulses;
    tx_done_in = 1'b1;
    @(negedge clk);
    tx_done_in = 1'b0;
    repeat (5) @(negedge clk);
    check_output("idle_done_counter", 32'(DS_counter_out), 32'(cnt0));
    check_output("idle_done_no_dv", 32'(dv_pulses - dv0), 32'd0);

    $display("[TB] ignored digest at byte 5, done held into LOAD at 7, boundary done at 12");
    apply_stimulus(ABC, 3, 5, 7, 12, -1);

    $display("[TB] timeout after byte 3, then restart");
    run_timeout();
    apply_stimulus(ABC, 2, -1, -1, -1, -1);

    $display("[TB] reset during byte 10, then restart");
    apply_stimulus(ABC, 2, -1, -1, -1, 10);
    apply_stimulus(ABC, 1, -1, -1, -1, -1);
    check_output("restart_byte0", 32'(rx[0]), 32'(table_v[0].exp));

    $display("[TB] random digests");
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom;
      apply_stimulus(rnd, int'($urandom_range(0, 6)), -1, -1, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
